// File: rtl/time_pkg.sv
// Shared widths, mode constants, BCD hour limits, load FSM states and hour helpers
// for the time_keeper clock.
package time_pkg;

  localparam int unsigned ONES_W     = 4;
  localparam int unsigned HR_TENS_W  = 2;
  localparam int unsigned MIN_TENS_W = 3;

  localparam bit MODE_12 = 1'b0;
  localparam bit MODE_24 = 1'b1;

  localparam logic [ONES_W-1:0]     DIGIT_MAX     = 4'd9;
  localparam logic [MIN_TENS_W-1:0] MIN_TENS_MAX  = 3'd5;
  localparam logic [HR_TENS_W-1:0]  HR24_TENS_MAX = 2'd2;
  localparam logic [ONES_W-1:0]     HR24_ONES_MAX = 4'd3;
  localparam logic [HR_TENS_W-1:0]  HR12_TENS_MAX = 2'd1;
  localparam logic [ONES_W-1:0]     HR12_ONES_MAX = 4'd2;

  typedef enum logic {
    LD_IDLE  = 1'b0,
    LD_CHECK = 1'b1
  } load_state_e;

  typedef struct packed {
    logic [HR_TENS_W-1:0] tens;
    logic [ONES_W-1:0]    ones;
  } hour_t;

  localparam hour_t HR24_RESET     = '{tens: 2'd0, ones: 4'd0};
  localparam hour_t HR12_RESET     = '{tens: 2'd1, ones: 4'd2};
  localparam hour_t HR24_LAST      = '{tens: 2'd2, ones: 4'd3};
  localparam hour_t HR_BEFORE_NOON = '{tens: 2'd1, ones: 4'd1};

  // Next BCD hour with mode wrap: 23->00 or 12->01.
  function automatic hour_t hour_next(input hour_t h, input bit mode_24h);
    hour_t n;
    n = h;
    if (mode_24h == MODE_24 && h == HR24_LAST) begin
      n = HR24_RESET;
    end else if (mode_24h == MODE_12 && h == HR12_RESET) begin
      n.tens = 2'd0;
      n.ones = 4'd1;
    end else if (h.ones == DIGIT_MAX) begin
      n.tens = h.tens + 2'd1;
      n.ones = 4'd0;
    end else begin
      n.ones = h.ones + 4'd1;
    end
    return n;
  endfunction

  function automatic logic hour_valid(input hour_t h, input bit mode_24h);
    if (h.ones > DIGIT_MAX) return 1'b0;
    if (mode_24h == MODE_24)
      return (h.tens < HR24_TENS_MAX) ||
             (h.tens == HR24_TENS_MAX && h.ones <= HR24_ONES_MAX);
    return (h.tens == 2'd0 && h.ones != 4'd0) ||
           (h.tens == HR12_TENS_MAX && h.ones <= HR12_ONES_MAX);
  endfunction

endpackage

// File: rtl/bcd_mod60.sv
// BCD minute counter 00-59 with enable, synchronous load (priority) and carry at 59.
module bcd_mod60
  import time_pkg::*;
(
  input  logic                  clk256,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [MIN_TENS_W-1:0] load_tens,
  input  logic [ONES_W-1:0]     load_ones,
  output logic [MIN_TENS_W-1:0] tens,
  output logic [ONES_W-1:0]     ones,
  output logic                  carry_c
);

  assign carry_c = en && (tens == MIN_TENS_MAX) && (ones == DIGIT_MAX);

  always_ff @(posedge clk256 or negedge reset_n) begin
    if (!reset_n) begin
      tens <= '0;
      ones <= '0;
    end else if (load) begin
      tens <= load_tens;
      ones <= load_ones;
    end else if (en) begin
      if (ones == DIGIT_MAX) begin
        ones <= '0;
        tens <= (tens == MIN_TENS_MAX) ? '0 : tens + 3'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_keeper.sv
// Wall-clock time keeper: BCD hours/minutes advanced by a synchronised minute
// level, with set-mode increments and a validated load handshake.
module time_keeper
  import time_pkg::*;
#(
  parameter bit MODE_24H = MODE_24
) (
  input  logic                  clk256,
  input  logic                  reset_n,
  input  logic                  one_minute,
  input  logic                  hold,
  input  logic                  inc_min,
  input  logic                  inc_hour,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [5:0]            load_hr,
  input  logic [6:0]            load_min,
  input  logic                  load_pm,
  output logic [HR_TENS_W-1:0]  hr_tens,
  output logic [ONES_W-1:0]     hr_ones,
  output logic [MIN_TENS_W-1:0] min_tens,
  output logic [ONES_W-1:0]     min_ones,
  output logic                  pm,
  output logic                  minute_tick,
  output logic                  day_tick,
  output logic                  load_err
);

  logic        sync1, sync2, prev, armed;
  logic [1:0]  fill;
  logic        tick_c;
  load_state_e state, state_next;
  logic        accept_c, load_write_c, load_bad_c, fields_ok_c;
  logic        pending, adv_c, defer_c;
  logic        min_en_c, min_carry_c, hr_step_c, day_c;
  hour_t       hr, hr_next_c, cap_hr;
  logic [MIN_TENS_W-1:0] cap_min_tens;
  logic [ONES_W-1:0]     cap_min_ones;
  logic        cap_pm;

  // Synchroniser + edge detect; armed only after a low level is seen, so a level
  // already high at reset release does not count as an edge.
  always_ff @(posedge clk256 or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      sync1 <= one_minute;
      sync2 <= sync1;
      prev  <= sync2;
      fill  <= {fill[0], 1'b1};
      armed <= armed | (fill[1] & ~sync2);
    end
  end

  assign tick_c = sync2 & ~prev & armed;

  always_ff @(posedge clk256 or negedge reset_n) begin
    if (!reset_n) state <= LD_IDLE;
    else          state <= state_next;
  end

  assign fields_ok_c = hour_valid(cap_hr, MODE_24H) &&
                       (cap_min_tens <= MIN_TENS_MAX) && (cap_min_ones <= DIGIT_MAX);

  always_comb begin
    state_next   = state;
    accept_c     = 1'b0;
    load_write_c = 1'b0;
    load_bad_c   = 1'b0;
    case (state)
      LD_IDLE: begin
        if (load_valid) begin
          accept_c   = 1'b1;
          state_next = LD_CHECK;
        end
      end
      LD_CHECK: begin
        state_next = LD_IDLE;
        if (fields_ok_c) load_write_c = 1'b1;
        else             load_bad_c   = 1'b1;
      end
      default: state_next = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk256 or negedge reset_n) begin
    if (!reset_n) begin
      cap_hr       <= '0;
      cap_min_tens <= '0;
      cap_min_ones <= '0;
      cap_pm       <= 1'b0;
    end else if (accept_c) begin
      cap_hr       <= hour_t'(load_hr);
      cap_min_tens <= load_min[6:4];
      cap_min_ones <= load_min[3:0];
      cap_pm       <= load_pm;
    end
  end

  // Ticks landing on acceptance or CHECK wait one slot and apply to the loaded time.
  assign defer_c = tick_c && !hold && (accept_c || state == LD_CHECK);
  assign adv_c   = (state == LD_IDLE) && !hold && ((tick_c && !accept_c) || pending);

  always_ff @(posedge clk256 or negedge reset_n) begin
    if (!reset_n)     pending <= 1'b0;
    else if (hold)    pending <= 1'b0;
    else if (defer_c) pending <= 1'b1;
    else if (adv_c)   pending <= 1'b0;
  end

  assign min_en_c  = adv_c || (hold && inc_min);
  assign hr_step_c = (adv_c && min_carry_c) || (hold && inc_hour);
  assign hr_next_c = hour_next(hr, MODE_24H);
  assign day_c     = adv_c && min_carry_c &&
                     ((MODE_24H == MODE_24) ? (hr == HR24_LAST) : (hr == HR_BEFORE_NOON && pm));

  bcd_mod60 u_minutes (
    .clk256    (clk256),
    .reset_n   (reset_n),
    .en        (min_en_c),
    .load      (load_write_c),
    .load_tens (cap_min_tens),
    .load_ones (cap_min_ones),
    .tens      (min_tens),
    .ones      (min_ones),
    .carry_c   (min_carry_c)
  );

  always_ff @(posedge clk256 or negedge reset_n) begin
    if (!reset_n) begin
      hr <= (MODE_24H == MODE_24) ? HR24_RESET : HR12_RESET;
      pm <= 1'b0;
    end else if (load_write_c) begin
      hr <= cap_hr;
      pm <= (MODE_24H == MODE_24) ? 1'b0 : cap_pm;
    end else if (hr_step_c) begin
      hr <= hr_next_c;
      if (MODE_24H == MODE_12 && hr == HR_BEFORE_NOON) pm <= ~pm;
    end
  end

  assign hr_tens = hr.tens;
  assign hr_ones = hr.ones;

  always_ff @(posedge clk256 or negedge reset_n) begin
    if (!reset_n) begin
      minute_tick <= 1'b0;
      day_tick    <= 1'b0;
      load_err    <= 1'b0;
      load_ready  <= 1'b1;
    end else begin
      minute_tick <= adv_c;
      day_tick    <= day_c;
      load_err    <= load_bad_c;
      load_ready  <= (state_next == LD_IDLE);
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper in 24h and 12h modes; each DUT is kept in
// reset while the other one is exercised.
module tb_time_keeper;

  typedef struct packed {
    logic [7:0] hr;
    logic [7:0] mn;
    logic       pm;
    logic       mtick;
    logic       dtick;
    logic       lerr;
    logic       rdy;
  } snap_t;

  logic       clk256 = 1'b0;
  logic       rst24, rst12;
  logic       one_minute, hold, inc_min, inc_hour, load_valid, load_pm;
  logic [5:0] load_hr;
  logic [6:0] load_min;

  logic [1:0] a_hr_tens, b_hr_tens;
  logic [3:0] a_hr_ones, b_hr_ones, a_min_ones, b_min_ones;
  logic [2:0] a_min_tens, b_min_tens;
  logic a_pm, a_minute_tick, a_day_tick, a_load_err, a_load_ready;
  logic b_pm, b_minute_tick, b_day_tick, b_load_err, b_load_ready;

  int checks = 0;
  int errors = 0;
  snap_t q24[$];
  snap_t q12[$];
  snap_t prev24, prev12;

  always #5 clk256 = ~clk256;

  time_keeper #(.MODE_24H(1'b1)) dut24 (
    .clk256(clk256), .reset_n(rst24), .one_minute(one_minute), .hold(hold),
    .inc_min(inc_min), .inc_hour(inc_hour), .load_valid(load_valid),
    .load_ready(a_load_ready), .load_hr(load_hr), .load_min(load_min),
    .load_pm(load_pm), .hr_tens(a_hr_tens), .hr_ones(a_hr_ones),
    .min_tens(a_min_tens), .min_ones(a_min_ones), .pm(a_pm),
    .minute_tick(a_minute_tick), .day_tick(a_day_tick), .load_err(a_load_err)
  );

  time_keeper #(.MODE_24H(1'b0)) dut12 (
    .clk256(clk256), .reset_n(rst12), .one_minute(one_minute), .hold(hold),
    .inc_min(inc_min), .inc_hour(inc_hour), .load_valid(load_valid),
    .load_ready(b_load_ready), .load_hr(load_hr), .load_min(load_min),
    .load_pm(load_pm), .hr_tens(b_hr_tens), .hr_ones(b_hr_ones),
    .min_tens(b_min_tens), .min_ones(b_min_ones), .pm(b_pm),
    .minute_tick(b_minute_tick), .day_tick(b_day_tick), .load_err(b_load_err)
  );

  function automatic snap_t mk(input logic [7:0] hr, input logic [7:0] mn, input logic p,
                               input logic mt, input logic dt, input logic le, input logic rdy);
    snap_t s;
    s.hr = hr; s.mn = mn; s.pm = p; s.mtick = mt; s.dtick = dt; s.lerr = le; s.rdy = rdy;
    return s;
  endfunction

  function automatic snap_t s24();
    return mk({2'b00, a_hr_tens, a_hr_ones}, {1'b0, a_min_tens, a_min_ones}, a_pm,
              a_minute_tick, a_day_tick, a_load_err, a_load_ready);
  endfunction

  function automatic snap_t s12();
    return mk({2'b00, b_hr_tens, b_hr_ones}, {1'b0, b_min_tens, b_min_ones}, b_pm,
              b_minute_tick, b_day_tick, b_load_err, b_load_ready);
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("%02h:%02h pm=%0b minute_tick=%0b day_tick=%0b load_err=%0b load_ready=%0b",
                     s.hr, s.mn, s.pm, s.mtick, s.dtick, s.lerr, s.rdy);
  endfunction

  function automatic logic is_event(input snap_t c, input snap_t p);
    return c.mtick || c.dtick || c.lerr ||
           ({c.hr, c.mn, c.pm, c.rdy} != {p.hr, p.mn, p.pm, p.rdy});
  endfunction

  task automatic check(input string name, input snap_t got, input snap_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
    end
  endtask

  task automatic check_rdy(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: load_ready got %0b, expected %0b", name, got, exp);
    end
  endtask

  // Monitors: any output change or pulse is an event matched against the queue.
  always @(negedge clk256) begin : mon24
    snap_t c;
    c = s24();
    if (rst24 === 1'b1 && is_event(c, prev24)) begin
      if (q24.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon24 unexpected event: got %s", fmt(c));
      end else begin
        check("mon24", c, q24.pop_front());
      end
    end
    prev24 = c;
  end

  always @(negedge clk256) begin : mon12
    snap_t c;
    c = s12();
    if (rst12 === 1'b1 && is_event(c, prev12)) begin
      if (q12.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon12 unexpected event: got %s", fmt(c));
      end else begin
        check("mon12", c, q12.pop_front());
      end
    end
    prev12 = c;
  end

  task automatic minute_edge();
    @(posedge clk256); #1 one_minute = 1'b1;
    repeat (6) @(posedge clk256);
    #1 one_minute = 1'b0;
    repeat (4) @(posedge clk256);
  endtask

  task automatic do_load(input logic [5:0] hr, input logic [6:0] mn, input logic p);
    @(posedge clk256);
    #1 load_valid = 1'b1; load_hr = hr; load_min = mn; load_pm = p;
    @(posedge clk256);
    #1 load_valid = 1'b0;
    @(negedge clk256) check_rdy("ready_low", a_load_ready & b_load_ready, 1'b0);
    @(negedge clk256) check_rdy("ready_back", a_load_ready & b_load_ready, 1'b1);
  endtask

  task automatic pulse_inc(input logic m, input logic h);
    @(posedge clk256); #1 inc_min = m; inc_hour = h;
    @(posedge clk256); #1 inc_min = 1'b0; inc_hour = 1'b0;
    repeat (2) @(posedge clk256);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst24 = 1'b0; rst12 = 1'b0;
    one_minute = 1'b0; hold = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
    load_valid = 1'b0; load_pm = 1'b0; load_hr = '0; load_min = '0;
    repeat (3) @(posedge clk256);
    #1 rst24 = 1'b1;
    @(negedge clk256) check("reset24", s24(), mk(8'h00, 8'h00, 0, 0, 0, 0, 1));

    // 23:58 -> 23:59 -> 00:00 with day_tick
    q24.push_back(mk(8'h00, 8'h00, 0, 0, 0, 0, 0));
    q24.push_back(mk(8'h23, 8'h58, 0, 0, 0, 0, 1));
    do_load(6'h23, 7'h58, 1'b0);
    q24.push_back(mk(8'h23, 8'h59, 0, 1, 0, 0, 1));
    minute_edge();
    q24.push_back(mk(8'h00, 8'h00, 0, 1, 1, 0, 1));
    minute_edge();

    // invalid loads leave time untouched
    q24.push_back(mk(8'h00, 8'h00, 0, 0, 0, 0, 0));
    q24.push_back(mk(8'h00, 8'h00, 0, 0, 0, 1, 1));
    do_load(6'h24, 7'h00, 1'b0);
    q24.push_back(mk(8'h00, 8'h00, 0, 0, 0, 0, 0));
    q24.push_back(mk(8'h00, 8'h00, 0, 0, 0, 1, 1));
    do_load(6'h10, 7'h60, 1'b0);

    // tick coincident with acceptance of 08:30
    q24.push_back(mk(8'h00, 8'h00, 0, 0, 0, 0, 0));
    q24.push_back(mk(8'h08, 8'h30, 0, 0, 0, 0, 1));
    q24.push_back(mk(8'h08, 8'h31, 0, 1, 0, 0, 1));
    @(posedge clk256); #1 one_minute = 1'b1;
    repeat (2) @(posedge clk256);
    #1 load_valid = 1'b1; load_hr = 6'h08; load_min = 7'h30; load_pm = 1'b0;
    @(posedge clk256); #1 load_valid = 1'b0;
    repeat (4) @(posedge clk256);
    #1 one_minute = 1'b0;
    repeat (4) @(posedge clk256);

    // set mode
    @(posedge clk256); #1 hold = 1'b1;
    q24.push_back(mk(8'h08, 8'h31, 0, 0, 0, 0, 0));
    q24.push_back(mk(8'h10, 8'h59, 0, 0, 0, 0, 1));
    do_load(6'h10, 7'h59, 1'b0);
    q24.push_back(mk(8'h10, 8'h00, 0, 0, 0, 0, 1));
    pulse_inc(1'b1, 1'b0);
    q24.push_back(mk(8'h10, 8'h00, 0, 0, 0, 0, 0));
    q24.push_back(mk(8'h23, 8'h45, 0, 0, 0, 0, 1));
    do_load(6'h23, 7'h45, 1'b0);
    q24.push_back(mk(8'h00, 8'h45, 0, 0, 0, 0, 1));
    pulse_inc(1'b0, 1'b1);
    q24.push_back(mk(8'h01, 8'h46, 0, 0, 0, 0, 1));
    pulse_inc(1'b1, 1'b1);
    minute_edge();
    @(posedge clk256); #1 hold = 1'b0;

    // reset during CHECK with one_minute high
    q24.push_back(mk(8'h01, 8'h47, 0, 1, 0, 0, 1));
    minute_edge();
    q24.push_back(mk(8'h01, 8'h47, 0, 0, 0, 0, 0));
    @(posedge clk256);
    #1 one_minute = 1'b1; load_valid = 1'b1; load_hr = 6'h12; load_min = 7'h34; load_pm = 1'b0;
    @(posedge clk256); #1 load_valid = 1'b0;
    @(negedge clk256); #1 rst24 = 1'b0;
    @(negedge clk256) check("reset_mid_check", s24(), mk(8'h00, 8'h00, 0, 0, 0, 0, 1));
    repeat (3) @(posedge clk256);
    #1 rst24 = 1'b1;
    repeat (10) @(posedge clk256);
    #1 one_minute = 1'b0;
    repeat (4) @(posedge clk256);
    q24.push_back(mk(8'h00, 8'h01, 0, 1, 0, 0, 1));
    minute_edge();
    repeat (4) @(posedge clk256);

    // 12-hour instance
    #1 rst24 = 1'b0;
    repeat (2) @(posedge clk256);
    #1 rst12 = 1'b1;
    @(negedge clk256) check("reset12", s12(), mk(8'h12, 8'h00, 0, 0, 0, 0, 1));
    q12.push_back(mk(8'h12, 8'h00, 0, 0, 0, 0, 0));
    q12.push_back(mk(8'h11, 8'h59, 0, 0, 0, 0, 1));
    do_load(6'h11, 7'h59, 1'b0);
    q12.push_back(mk(8'h12, 8'h00, 1, 1, 0, 0, 1));
    minute_edge();
    q12.push_back(mk(8'h12, 8'h00, 1, 0, 0, 0, 0));
    q12.push_back(mk(8'h11, 8'h59, 1, 0, 0, 0, 1));
    do_load(6'h11, 7'h59, 1'b1);
    q12.push_back(mk(8'h12, 8'h00, 0, 1, 1, 0, 1));
    minute_edge();
    q12.push_back(mk(8'h12, 8'h00, 0, 0, 0, 0, 0));
    q12.push_back(mk(8'h12, 8'h59, 0, 0, 0, 0, 1));
    do_load(6'h12, 7'h59, 1'b0);
    q12.push_back(mk(8'h01, 8'h00, 0, 1, 0, 0, 1));
    minute_edge();
    q12.push_back(mk(8'h01, 8'h00, 0, 0, 0, 0, 0));
    q12.push_back(mk(8'h01, 8'h00, 0, 0, 0, 1, 1));
    do_load(6'h00, 7'h30, 1'b0);
    q12.push_back(mk(8'h01, 8'h00, 0, 0, 0, 0, 0));
    q12.push_back(mk(8'h01, 8'h00, 0, 0, 0, 1, 1));
    do_load(6'h13, 7'h00, 1'b1);
    repeat (10) @(posedge clk256);

    checks++;
    if (q24.size() != 0) begin
      errors++;
      $display("FAIL drain24: %0d expected events still pending, required 0", q24.size());
    end
    checks++;
    if (q12.size() != 0) begin
      errors++;
      $display("FAIL drain12: %0d expected events still pending, required 0", q12.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
